// File: rtl/psum_writeback_pkg.sv
// rtl/psum_writeback_pkg.sv - shared FSM encoding and saturation limits for psum_writeback
//
// Purpose: state encoding for the writeback FSM and signed saturation limits
//          derived from the psum lane width.
// Ports:   none (package).

package psum_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest positive value of a bw-bit two's complement lane (bw <= 31).
  function automatic logic signed [31:0] sat_max(input int bw);
    return (32'sd1 <<< (bw - 1)) - 32'sd1;
  endfunction

  // Most negative value of a bw-bit two's complement lane (bw <= 31).
  function automatic logic signed [31:0] sat_min(input int bw);
    return -(32'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_lane.sv
// rtl/psum_lane.sv - one lane of psum accumulate: saturating add plus optional ReLU
//
// Purpose: combinational lane math for the writeback stage.
// Ports:
//   in_val     in   psum_bw  incoming psum (signed)
//   old_val    in   psum_bw  previously accumulated value (signed)
//   first_pass in   1        pass 0: pass in_val through, ignore old_val
//   last_pass  in   1        final pass: clamp negative results to 0
//   out_val    out  psum_bw  value to write back

module psum_lane
  import psum_writeback_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] in_val,
  input  logic [psum_bw-1:0] old_val,
  input  logic               first_pass,
  input  logic               last_pass,
  output logic [psum_bw-1:0] out_val
);

  localparam logic [psum_bw-1:0] SAT_MAX = psum_bw'(sat_max(psum_bw));
  localparam logic [psum_bw-1:0] SAT_MIN = psum_bw'(sat_min(psum_bw));

  logic [psum_bw:0]   wide;
  logic [psum_bw-1:0] sum;

  always_comb begin
    wide = {in_val[psum_bw-1], in_val} + {old_val[psum_bw-1], old_val};
    if (first_pass) begin
      sum = in_val;
    end else if (wide[psum_bw] != wide[psum_bw-1]) begin
      // Sign-extended top bits disagree: overflow, direction given by true sign.
      sum = wide[psum_bw] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = wide[psum_bw-1:0];
    end
    out_val = (last_pass && sum[psum_bw-1]) ? '0 : sum;
  end

endmodule

// File: rtl/psum_writeback.sv
// rtl/psum_writeback.sv - multi-pass psum accumulation into a two-port SRAM
//
// Purpose: accepts the psum vector stream and read-modify-writes it into the
//          psum SRAM over num_passes passes of num_words vectors; ReLU on the
//          final pass; pulses done when the final write has been issued.
// Ports:
//   clk, reset              clock, async active-low reset
//   start                   1-cycle start pulse (IDLE only)
//   num_words, num_passes   job shape, sampled on start
//   in_valid/in_data/in_ready  psum vector stream
//   rd_en/rd_addr/mem_q     SRAM read port (1-cycle read latency)
//   wr_en/wr_addr/wr_data   SRAM write port
//   busy, done              status to top FSM

module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 7,
  parameter int pass_w  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w:0]        num_words,
  input  logic [pass_w-1:0]      num_passes,
  input  logic                   in_valid,
  input  logic [psum_bw*col-1:0] in_data,
  output logic                   in_ready,
  output logic                   rd_en,
  output logic [addr_w-1:0]      rd_addr,
  input  logic [psum_bw*col-1:0] mem_q,
  output logic                   wr_en,
  output logic [addr_w-1:0]      wr_addr,
  output logic [psum_bw*col-1:0] wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam int vec_w = psum_bw * col;

  state_t             state_q, state_d;
  logic [addr_w:0]    nw_q, nw_d;
  logic [pass_w-1:0]  np_q, np_d;
  logic [addr_w-1:0]  word_cnt_q, word_cnt_d;
  logic [pass_w-1:0]  pass_cnt_q, pass_cnt_d;
  logic               s2_valid_q, s2_valid_d;
  logic [vec_w-1:0]   s2_data_q, s2_data_d;
  logic [addr_w-1:0]  s2_addr_q, s2_addr_d;
  logic               s2_first_q, s2_first_d;
  logic               s2_last_q, s2_last_d;
  logic               s2_fwd_q, s2_fwd_d;
  logic [vec_w-1:0]   fwd_data_q, fwd_data_d;
  logic [vec_w-1:0]   wr_hold_q, wr_hold_d;

  logic               beat;
  logic               last_word;
  logic               first_pass_now;
  logic               last_pass_now;
  logic               fwd_hit;
  logic [vec_w-1:0]   old_vec;
  logic [vec_w-1:0]   lane_out;

  assign in_ready       = (state_q == ST_RUN);
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign beat           = in_valid && in_ready;
  assign last_word      = ({1'b0, word_cnt_q} == (nw_q - (addr_w + 1)'(1)));
  assign first_pass_now = (pass_cnt_q == '0);
  assign last_pass_now  = (pass_cnt_q == (np_q - pass_w'(1)));

  assign rd_en   = beat && !first_pass_now;
  assign rd_addr = word_cnt_q;
  assign wr_en   = s2_valid_q;
  assign wr_addr = s2_addr_q;

  // A read of the address being written this cycle would return the stale
  // word; the in-flight result is captured and used instead of mem_q.
  assign fwd_hit = rd_en && s2_valid_q && (s2_addr_q == word_cnt_q);
  assign old_vec = s2_fwd_q ? fwd_data_q : mem_q;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane #(.psum_bw(psum_bw)) u_lane (
      .in_val     (s2_data_q[psum_bw*i +: psum_bw]),
      .old_val    (old_vec[psum_bw*i +: psum_bw]),
      .first_pass (s2_first_q),
      .last_pass  (s2_last_q),
      .out_val    (lane_out[psum_bw*i +: psum_bw])
    );
  end

  // Bubbles keep presenting the last written vector.
  assign wr_data = s2_valid_q ? lane_out : wr_hold_q;

  always_comb begin
    state_d    = state_q;
    nw_d       = nw_q;
    np_d       = np_q;
    word_cnt_d = word_cnt_q;
    pass_cnt_d = pass_cnt_q;
    s2_valid_d = 1'b0;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_fwd_d   = s2_fwd_q;
    fwd_data_d = fwd_data_q;
    wr_hold_d  = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (start && (num_words != '0) && (num_passes != '0)) begin
          state_d    = ST_RUN;
          nw_d       = num_words;
          np_d       = num_passes;
          word_cnt_d = '0;
          pass_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (beat) begin
          s2_valid_d = 1'b1;
          s2_data_d  = in_data;
          s2_addr_d  = word_cnt_q;
          s2_first_d = first_pass_now;
          s2_last_d  = last_pass_now;
          s2_fwd_d   = fwd_hit;
          fwd_data_d = wr_data;
          if (last_word) begin
            word_cnt_d = '0;
            pass_cnt_d = pass_cnt_q + pass_w'(1);
            if (last_pass_now) state_d = ST_DRAIN;
          end else begin
            word_cnt_d = word_cnt_q + addr_w'(1);
          end
        end
      end
      // The final beat is in stage 2 and is written during this cycle.
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      nw_q       <= '0;
      np_q       <= '0;
      word_cnt_q <= '0;
      pass_cnt_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_fwd_q   <= 1'b0;
      fwd_data_q <= '0;
      wr_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      nw_q       <= nw_d;
      np_q       <= np_d;
      word_cnt_q <= word_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      s2_fwd_q   <= s2_fwd_d;
      fwd_data_q <= fwd_data_d;
      wr_hold_q  <= wr_hold_d;
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// tb/tb_psum_writeback.sv - scoreboard bench for psum_writeback

module tb_psum_writeback;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 7;
  localparam int PW  = 4;
  localparam int VW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [PW-1:0] num_passes = '0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] mem_q = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic          busy;
  logic          done;

  psum_writeback #(.col(COL), .psum_bw(BW), .addr_w(AW), .pass_w(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .num_passes(num_passes), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_en(rd_en), .rd_addr(rd_addr), .mem_q(mem_q),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-port SRAM model: read data registered one cycle after rd_en.
  logic [VW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) mem_q <= mem[rd_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = -10;

  logic [AW-1:0] exp_addr [$];
  logic [VW-1:0] exp_data [$];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  // Even lanes get a, odd lanes get b.
  function automatic logic [VW-1:0] alt(input int a, input int b);
    logic [VW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = (i % 2 == 0) ? BW'(a) : BW'(b);
    return r;
  endfunction

  task automatic expect_wr(input int a, input logic [VW-1:0] d);
    exp_addr.push_back(AW'(a));
    exp_data.push_back(d);
  endtask

  // Monitor: pops the scoreboard on every write, counts reads and done pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        wr_cnt++;
        chk("sb_has_entry", VW'(exp_addr.size() != 0), VW'(1));
        if (exp_addr.size() != 0) begin
          chk("wr_addr", VW'(wr_addr), VW'(exp_addr.pop_front()));
          chk("wr_data", wr_data, exp_data.pop_front());
        end
        last_wr_cyc = cyc;
      end
      if (rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_latency", VW'(cyc), VW'(last_wr_cyc + 1));
      end
    end
    cyc++;
  end

  task automatic do_start(input int nw, input int np);
    num_words  = (AW + 1)'(nw);
    num_passes = PW'(np);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [VW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 20) chk("beat_timeout", VW'(in_ready), VW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    logic seen;
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", VW'(seen), VW'(1));
    @(posedge clk); #1;
    chk("sb_drained", VW'(exp_addr.size()), VW'(0));
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_rd_en", VW'(rd_en), VW'(0));
    chk("rst_wr_en", VW'(wr_en), VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_rd_addr", VW'(rd_addr), VW'(0));
    chk("rst_wr_addr", VW'(wr_addr), VW'(0));
    chk("rst_wr_data", wr_data, VW'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: reset in the middle of a run.
    clear_counts();
    do_start(4, 1);
    expect_wr(0, rep(9));
    send_beat(rep(9));
    @(negedge clk);
    chk("t1_busy_before", VW'(busy), VW'(1));
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", VW'(in_ready), VW'(0));
    chk("t1_wr_en", VW'(wr_en), VW'(0));
    chk("t1_busy", VW'(busy), VW'(0));
    chk("t1_done", VW'(done), VW'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_still_idle", VW'(busy), VW'(0));
    chk("t1_no_done", VW'(done_cnt), VW'(0));
    @(posedge clk); #1;

    // Zero-sized jobs are ignored.
    do_start(0, 2);
    @(negedge clk);
    chk("zero_words_ignored", VW'(busy), VW'(0));
    @(posedge clk); #1;
    do_start(3, 0);
    @(negedge clk);
    chk("zero_passes_ignored", VW'(busy), VW'(0));
    @(posedge clk); #1;

    // Test 2: single pass, ReLU on raw input, no reads.
    clear_counts();
    do_start(4, 1);
    expect_wr(0, rep(5));
    expect_wr(1, rep(0));
    expect_wr(2, rep(7));
    expect_wr(3, rep(0));
    send_beat(rep(5));
    send_beat(rep(-3));
    send_beat(rep(7));
    send_beat(rep(0));
    wait_done();
    chk("t2_no_reads", VW'(rd_cnt), VW'(0));
    chk("t2_done_once", VW'(done_cnt), VW'(1));

    // Test 3: three passes of +100 over two words.
    clear_counts();
    do_start(2, 3);
    expect_wr(0, rep(100)); expect_wr(1, rep(100));
    expect_wr(0, rep(200)); expect_wr(1, rep(200));
    expect_wr(0, rep(300)); expect_wr(1, rep(300));
    for (int i = 0; i < 6; i++) send_beat(rep(100));
    wait_done();
    chk("t3_reads", VW'(rd_cnt), VW'(4));

    // Test 4: saturation, then ReLU of the saturated negative.
    clear_counts();
    do_start(2, 2);
    expect_wr(0, alt(32000, -32000));
    expect_wr(1, rep(-5));
    expect_wr(0, alt(32767, 0));
    expect_wr(1, rep(3));
    send_beat(alt(32000, -32000));
    send_beat(rep(-5));
    send_beat(alt(1000, -1000));
    send_beat(rep(8));
    wait_done();

    // Test 5: single word, back-to-back beats need forwarding.
    clear_counts();
    do_start(1, 4);
    expect_wr(0, rep(1));
    expect_wr(0, rep(2));
    expect_wr(0, rep(3));
    expect_wr(0, rep(4));
    for (int i = 0; i < 4; i++) send_beat(rep(1));
    wait_done();
    chk("t5_mem0", mem[0], rep(4));

    // Test 6: random gaps, plus a start pulse while busy.
    clear_counts();
    mem[0] = '0;
    mem[1] = '0;
    do_start(2, 3);
    expect_wr(0, rep(100)); expect_wr(1, rep(100));
    expect_wr(0, rep(200)); expect_wr(1, rep(200));
    expect_wr(0, rep(300)); expect_wr(1, rep(300));
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (i == 2) do_start(1, 1);
      send_beat(rep(100));
    end
    wait_done();
    chk("t6_mem0", mem[0], rep(300));
    chk("t6_mem1", mem[1], rep(300));
    chk("t6_wr_count", VW'(wr_cnt), VW'(6));
    chk("t6_done_once", VW'(done_cnt), VW'(1));
    repeat (3) @(negedge clk);
    chk("t6_idle_after", VW'(busy), VW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
